read_filter_pipe: RTL

Next-generation read/filter stage between the lock unit and the compute unit. It pops {mod, key, msg} entries from the lock-read FIFO, computes each record's DDR address from the key hash and issues record reads to the DDR read master. Up to MAX_OUTSTANDING reads are tracked in an internal pending FIFO, so request issue overlaps data return. Each returned record is tagged with a filter bit from two IEEE-754 threshold compares and pushed to the read-compute FIFO. Key width, record width, record size and delta-field position are all parametrised.

---
 rtl/read_filter_pipe_if.sv | 57 +++++
 rtl/read_filter_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/read_filter_pipe_if.sv
// read_filter_pipe_if
//   Bus bundle between read_filter_pipe and its surroundings: the lock-read
//   FIFO (input side), the read-compute FIFO (output side) and the DDR read
//   master (control + user data ports).
//   master modport : the read/filter pipe itself
//   slave modport  : the FIFOs and read master around it
//
//   lock_read_fifo_q/_empty/_rdreq          {mod, key, msg} input FIFO, msg in LSBs
//   read_compute_fifo_data/_full/_wrreq     {mod, filter, msg, record} output FIFO
//   control_fixed_location/_read_base/_read_length/_go/_done   read master control
//   user_read_buffer/_data_available/_buffer_data              read master data (show-ahead)
interface read_filter_pipe_if #(
   parameter int ADDRESS_WIDTH = 31,
   parameter int KEY_WIDTH     = 32,
   parameter int MSG_WIDTH     = 32,
   parameter int RECORD_WIDTH  = 256
);
   logic [KEY_WIDTH+MSG_WIDTH:0]      lock_read_fifo_q;
   logic                              lock_read_fifo_empty;
   logic                              lock_read_fifo_rdreq;

   logic [MSG_WIDTH+RECORD_WIDTH+1:0] read_compute_fifo_data;
   logic                              read_compute_fifo_full;
   logic                              read_compute_fifo_wrreq;

   logic                              control_fixed_location;
   logic [ADDRESS_WIDTH-1:0]          control_read_base;
   logic [ADDRESS_WIDTH-1:0]          control_read_length;
   logic                              control_go;
   logic                              control_done;

   logic                              user_read_buffer;
   logic                              user_data_available;
   logic [RECORD_WIDTH-1:0]           user_buffer_data;

   modport master (
      input  lock_read_fifo_q, lock_read_fifo_empty,
      output lock_read_fifo_rdreq,
      output read_compute_fifo_data, read_compute_fifo_wrreq,
      input  read_compute_fifo_full,
      output control_fixed_location, control_read_base, control_read_length, control_go,
      input  control_done,
      output user_read_buffer,
      input  user_data_available, user_buffer_data
   );

   modport slave (
      output lock_read_fifo_q, lock_read_fifo_empty,
      input  lock_read_fifo_rdreq,
      input  read_compute_fifo_data, read_compute_fifo_wrreq,
      output read_compute_fifo_full,
      input  control_fixed_location, control_read_base, control_read_length, control_go,
      output control_done,
      input  user_read_buffer,
      output user_data_available, user_buffer_data
   );
endinterface

// File: rtl/read_filter_pipe.sv
// read_filter_pipe
//   Read/filter stage between the lock unit and the compute unit. Pops
//   {mod, key, msg} entries, issues one DDR record read per entry at
//   DDR_BASE + ((key >> log_2_num_workers_in) << RECORD_SHIFT), keeps up to
//   MAX_OUTSTANDING {mod, msg} pairs in a pending FIFO so issue overlaps data
//   return, and tags each returned record with filter = !(delta >= threshold
//   && delta >= filter_threshold) using IEEE-754 single-precision ordering.
//
//   clk, reset                : clock, synchronous active-high reset
//   bus (master)              : FIFO / read-master bundle, see read_filter_pipe_if
//   log_2_num_workers_in      : key hash shift
//   threshold                 : float threshold
//   filter_threshold          : float filter threshold
//
//   Optional feature, macro FILTER_STATS_EN:
//   stat_clear                : synchronous clear of both counters (wins over increment)
//   stat_pass_count           : records written with filter = 0 (wraps)
//   stat_filter_count         : records written with filter = 1 (wraps)
module read_filter_pipe #(
   parameter longint unsigned DDR_BASE = 0,
   parameter int ADDRESS_WIDTH   = 31,
   parameter int KEY_WIDTH       = 32,
   parameter int MSG_WIDTH       = 32,
   parameter int RECORD_WIDTH    = 256,
   parameter int RECORD_SHIFT    = 5,
   parameter int DELTA_LSB       = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic               clk,
   input  logic               reset,
   read_filter_pipe_if.master bus,
   input  logic [31:0]        log_2_num_workers_in,
   input  logic [31:0]        threshold,
   input  logic [31:0]        filter_threshold
`ifdef FILTER_STATS_EN
   ,
   input  logic               stat_clear,
   output logic [31:0]        stat_pass_count,
   output logic [31:0]        stat_filter_count
`endif
);
   localparam int PEND_AW = $clog2(MAX_OUTSTANDING);
   localparam int ENTRY_W = 1 + MSG_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] RECORD_LEN = ADDRESS_WIDTH'(1) << RECORD_SHIFT;

   typedef enum logic [2:0] {I_IDLE, I_POP, I_WAIT, I_GO, I_HOLD} issue_state_t;
   typedef enum logic [1:0] {R_IDLE, R_CMP, R_WRITE} ret_state_t;

   // Maps an IEEE-754 single onto a signed integer with the same ordering;
   // both zeros map to 0 so -0 == +0.
   function automatic logic signed [32:0] float_order(input logic [31:0] f);
      logic signed [32:0] mag;
      mag = {2'b00, f[30:0]};
      return f[31] ? -mag : mag;
   endfunction

   // ---------------------------------------------------------------- issue side
   logic                     q_mod;
   logic [KEY_WIDTH-1:0]     q_key;
   logic [MSG_WIDTH-1:0]     q_msg;
   logic [KEY_WIDTH-1:0]     key_shifted;
   logic [ADDRESS_WIDTH-1:0] issue_addr;

   assign {q_mod, q_key, q_msg} = bus.lock_read_fifo_q;
   assign key_shifted = q_key >> log_2_num_workers_in;
   assign issue_addr  = ADDRESS_WIDTH'(DDR_BASE) + (ADDRESS_WIDTH'(key_shifted) << RECORD_SHIFT);
   assign bus.control_fixed_location = 1'b0;

   issue_state_t issue_state, issue_next;
   logic         pend_push, pend_pop, pend_full, pend_empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) issue_state <= I_IDLE;
      else       issue_state <= issue_next;
   end

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      issue_next               = issue_state;
      bus.lock_read_fifo_rdreq = 1'b0;
      bus.control_go           = 1'b0;
      bus.control_read_base    = '0;
      bus.control_read_length  = '0;
      pend_push                = 1'b0;
      case (issue_state)
         I_IDLE: if (!bus.lock_read_fifo_empty && !pend_full && bus.control_done) issue_next = I_POP;
         I_POP: begin
            bus.lock_read_fifo_rdreq = 1'b1;
            issue_next               = I_WAIT;
         end
         I_WAIT: issue_next = I_GO;          // q becomes valid during this cycle
         I_GO: begin
            bus.control_go          = 1'b1;
            bus.control_read_base   = issue_addr;
            bus.control_read_length = RECORD_LEN;
            pend_push               = 1'b1;
            issue_next              = I_HOLD;
         end
         I_HOLD: issue_next = I_IDLE;        // lets control_done fall before the next check
         default: issue_next = I_IDLE;
      endcase
   end

   // ------------------------------------------------------------- pending FIFO
   logic [ENTRY_W-1:0] pend_mem [MAX_OUTSTANDING];
   logic [PEND_AW-1:0] pend_wr_ptr, pend_rd_ptr;
   logic [PEND_AW:0]   pend_count;
   logic               pend_mod;
   logic [MSG_WIDTH-1:0] pend_msg;

   assign pend_full  = (pend_count == (PEND_AW+1)'(MAX_OUTSTANDING));
   assign pend_empty = (pend_count == '0);
   assign {pend_mod, pend_msg} = pend_mem[pend_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_wr_ptr <= '0;
         pend_rd_ptr <= '0;
         pend_count  <= '0;
      end else begin
         if (pend_push) pend_wr_ptr <= pend_wr_ptr + 1'b1;
         if (pend_pop)  pend_rd_ptr <= pend_rd_ptr + 1'b1;
         case ({pend_push, pend_pop})
            2'b10:   pend_count <= pend_count + 1'b1;
            2'b01:   pend_count <= pend_count - 1'b1;
            default: pend_count <= pend_count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (pend_push) pend_mem[pend_wr_ptr] <= {q_mod, q_msg};
   end

   // -------------------------------------------------------------- return side
   ret_state_t              ret_state, ret_next;
   logic                    accept;
   logic [RECORD_WIDTH-1:0] rec_r;
   logic [MSG_WIDTH-1:0]    msg_r;
   logic                    mod_r, filter_r;
   logic [31:0]             delta;

   // Data without a pending entry is a protocol error and is left unpopped.
   assign accept = bus.user_data_available && !pend_empty && !bus.read_compute_fifo_full;
   assign delta  = rec_r[DELTA_LSB +: 32];
   assign bus.read_compute_fifo_data = {mod_r, filter_r, msg_r, rec_r};

   always_ff @(posedge clk) begin
      if (reset) ret_state <= R_IDLE;
      else       ret_state <= ret_next;
   end

   always_comb begin
      ret_next                    = ret_state;
      bus.user_read_buffer        = 1'b0;
      bus.read_compute_fifo_wrreq = 1'b0;
      pend_pop                    = 1'b0;
      case (ret_state)
         R_IDLE: if (accept) begin
            bus.user_read_buffer = 1'b1;
            pend_pop             = 1'b1;
            ret_next             = R_CMP;
         end
         R_CMP: ret_next = R_WRITE;
         R_WRITE: if (!bus.read_compute_fifo_full) begin
            bus.read_compute_fifo_wrreq = 1'b1;
            ret_next                    = R_IDLE;
         end
         default: ret_next = R_IDLE;
      endcase
   end

   // Output word registers; cleared on reset so the output bus reads 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         rec_r    <= '0;
         msg_r    <= '0;
         mod_r    <= 1'b0;
         filter_r <= 1'b0;
      end else begin
         if (pend_pop) begin
            rec_r <= bus.user_buffer_data;
            msg_r <= pend_msg;
            mod_r <= pend_mod;
         end
         // Thresholds are sampled here, so a change only affects later records.
         if (ret_state == R_CMP)
            filter_r <= !((float_order(delta) >= float_order(threshold)) &&
                          (float_order(delta) >= float_order(filter_threshold)));
      end
   end

`ifdef FILTER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
         stat_pass_count   <= '0;
         stat_filter_count <= '0;
      end else if (bus.read_compute_fifo_wrreq) begin
         if (filter_r) stat_filter_count <= stat_filter_count + 1'b1;
         else          stat_pass_count   <= stat_pass_count + 1'b1;
      end
   end
`endif
endmodule
